// File: rtl/fc1_weight_pkg.sv
// fc1_weight_pkg: shared types and sizing for the fc1 weight source/sink path
package fc1_weight_pkg;
   typedef enum logic {LOAD, DONE} state_t;
   function automatic int beats_per_tensor(input int d0, input int d1, input int p0, input int p1);
      return d0 * d1 / (p0 * p1);
   endfunction
endpackage

// File: rtl/fc1_weight_sink_if.sv
// fc1_weight_sink_if: valid/ready beat stream carrying unpacked weight elements
interface fc1_weight_sink_if #(
   parameter int P0 = 16,
   parameter int N  = 1
);
   logic [P0-1:0] data_in [N];
   logic          data_in_valid;
   logic          data_in_ready;
   modport master (output data_in, data_in_valid, input data_in_ready);
   modport slave  (input data_in, data_in_valid, output data_in_ready);
endinterface

// File: rtl/fc1_weight_ram.sv
// fc1_weight_ram: single-write buffer with a 2-stage registered read port matching the weight ROM
module fc1_weight_ram #(
   parameter int DW    = 16,
   parameter int DEPTH = 32,
   parameter int AW    = 6
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [DW-1:0] wdata,
   input  logic [AW-1:0] addr0,
   input  logic          ce0,
   output logic [DW-1:0] q0
);
   localparam int IW = DEPTH > 1 ? $clog2(DEPTH) : 1;
   logic [DW-1:0] mem [DEPTH];
   logic [DW-1:0] q0_t0;
   always_ff @(posedge clk)
      if (we) mem[IW'(waddr)] <= wdata;
   always_ff @(posedge clk)
      if (!rst) begin
         q0_t0 <= '0;
         q0    <= '0;
      end else if (ce0) begin
         q0_t0 <= mem[IW'(addr0)];
         q0    <= q0_t0;
      end
endmodule

// File: rtl/fc1_weight_sink.sv
// fc1_weight_sink: streams fc1 weight beats into a buffer readable through a ROM-style port
module fc1_weight_sink
   import fc1_weight_pkg::*;
#(
   parameter int WEIGHT_TENSOR_SIZE_DIM_0 = 32,
   parameter int WEIGHT_TENSOR_SIZE_DIM_1 = 1,
   parameter int WEIGHT_PRECISION_0       = 16,
   parameter int WEIGHT_PRECISION_1       = 3,
   parameter int WEIGHT_PARALLELISM_DIM_0 = 1,
   parameter int WEIGHT_PARALLELISM_DIM_1 = 1,
   parameter int IN_DEPTH   = beats_per_tensor(WEIGHT_TENSOR_SIZE_DIM_0, WEIGHT_TENSOR_SIZE_DIM_1,
                                               WEIGHT_PARALLELISM_DIM_0, WEIGHT_PARALLELISM_DIM_1),
   parameter int ADDR_WIDTH = $clog2(IN_DEPTH + 1)
) (
   input  logic                  clk,
   input  logic                  rst,
   fc1_weight_sink_if.slave      din,
   input  logic                  reload,
   output logic                  load_done,
   output logic [ADDR_WIDTH-1:0] beat_count,
   input  logic [ADDR_WIDTH-1:0] addr0,
   input  logic                  ce0,
   output logic [WEIGHT_PRECISION_0*WEIGHT_PARALLELISM_DIM_0*WEIGHT_PARALLELISM_DIM_1-1:0] q0
);
   localparam int N  = WEIGHT_PARALLELISM_DIM_0 * WEIGHT_PARALLELISM_DIM_1;
   localparam int P0 = WEIGHT_PRECISION_0;
   state_t                state;
   logic                  ready;
   logic [ADDR_WIDTH-1:0] wr_ptr;
   logic [P0*N-1:0]       wdata;
   logic                  accept;
   logic                  last;
   logic [31:0]           unused_frac;
   // fractional width travels with the weights as metadata only
   assign unused_frac       = WEIGHT_PRECISION_1;
   assign din.data_in_ready = ready;
   assign accept            = din.data_in_valid & ready & rst;
   assign last              = wr_ptr == ADDR_WIDTH'(IN_DEPTH - 1);
   for (genvar j = 0; j < N; j++) begin : g_pack
      assign wdata[P0*j +: P0] = din.data_in[j];
   end
   always_ff @(posedge clk)
      if (!rst) begin
         state      <= LOAD;
         wr_ptr     <= '0;
         beat_count <= '0;
         load_done  <= 1'b0;
         ready      <= 1'b0;
      end else if (reload) begin
         state      <= LOAD;
         wr_ptr     <= '0;
         beat_count <= '0;
         load_done  <= 1'b0;
         ready      <= 1'b1;
      end else if (accept) begin
         state      <= last ? DONE : LOAD;
         wr_ptr     <= last ? '0 : wr_ptr + 1'b1;
         beat_count <= beat_count + 1'b1;
         load_done  <= last;
         ready      <= !last;
      end else
         ready <= state == LOAD;
   fc1_weight_ram #(.DW(P0*N), .DEPTH(IN_DEPTH), .AW(ADDR_WIDTH)) u_ram (
      .clk   (clk),
      .rst   (rst),
      .we    (accept),
      .waddr (wr_ptr),
      .wdata (wdata),
      .addr0 (addr0),
      .ce0   (ce0),
      .q0    (q0)
   );
endmodule

// File: tb/tb_fc1_weight_sink.sv
// tb_fc1_weight_sink: directed checks of loading, DONE blocking, reload, reset and the read port
module tb_fc1_weight_sink;
   logic        clk = 1'b0;
   logic        rst;
   logic        reload;
   logic        load_done;
   logic [5:0]  beat_count;
   logic [5:0]  addr0;
   logic        ce0;
   logic [15:0] q0;
   int          errs = 0;
   int          checks = 0;
   int          exp_bc;
   fc1_weight_sink_if #(.P0(16), .N(1)) bus ();
   fc1_weight_sink dut (
      .clk        (clk),
      .rst        (rst),
      .din        (bus),
      .reload     (reload),
      .load_done  (load_done),
      .beat_count (beat_count),
      .addr0      (addr0),
      .ce0        (ce0),
      .q0         (q0)
   );
   always #5 clk = ~clk;
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask
   task automatic rd(input int a, input int exp);
      addr0 = 6'(a);
      ce0   = 1'b1;
      tick();
      tick();
      chk($sformatf("q0[%0d]", a), 32'(q0), 32'(exp));
   endtask
   task automatic load(input int base, input int n);
      for (int i = 0; i < n; i++) begin
         bus.data_in[0]    = 16'(base + i);
         bus.data_in_valid = 1'b1;
         chk("ready_load", 32'(bus.data_in_ready), 1);
         chk("done_low_load", 32'(load_done), 0);
         tick();
      end
      bus.data_in_valid = 1'b0;
   endtask
   task automatic pulse_reload();
      reload = 1'b1;
      tick();
      reload = 1'b0;
   endtask
   initial begin
      rst = 1'b0;
      reload = 1'b0;
      ce0 = 1'b0;
      addr0 = '0;
      bus.data_in[0] = '0;
      bus.data_in_valid = 1'b0;
      tick();
      tick();
      chk("rst_ready", 32'(bus.data_in_ready), 0);
      chk("rst_done", 32'(load_done), 0);
      chk("rst_bc", 32'(beat_count), 0);
      chk("rst_q0", 32'(q0), 0);
      rst = 1'b1;
      tick();
      chk("ready_after_rst", 32'(bus.data_in_ready), 1);
      load(0, 32);
      chk("s1_done", 32'(load_done), 1);
      chk("s1_ready", 32'(bus.data_in_ready), 0);
      chk("s1_bc", 32'(beat_count), 32);
      for (int a = 0; a < 32; a++) rd(a, a);
      bus.data_in[0] = 16'hFFFF;
      bus.data_in_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         chk("s3_ready", 32'(bus.data_in_ready), 0);
      end
      bus.data_in_valid = 1'b0;
      chk("s3_bc", 32'(beat_count), 32);
      chk("s3_done", 32'(load_done), 1);
      rd(0, 0);
      rd(31, 31);
      pulse_reload();
      chk("s4_done", 32'(load_done), 0);
      chk("s4_bc", 32'(beat_count), 0);
      chk("s4_ready", 32'(bus.data_in_ready), 1);
      load(100, 32);
      chk("s4_done_end", 32'(load_done), 1);
      for (int a = 0; a < 32; a++) rd(a, 100 + a);
      pulse_reload();
      exp_bc = 0;
      for (int c = 0; c < 400 && exp_bc < 32; c++) begin
         bus.data_in_valid = 1'($urandom_range(0, 1));
         bus.data_in[0]    = 16'(exp_bc);
         if (bus.data_in_valid && bus.data_in_ready) exp_bc++;
         tick();
         chk("s2_bc", 32'(beat_count), 32'(exp_bc));
      end
      bus.data_in_valid = 1'b0;
      chk("s2_done", 32'(load_done), 1);
      for (int a = 0; a < 32; a++) rd(a, a);
      pulse_reload();
      load(200, 31);
      bus.data_in[0] = 16'd231;
      bus.data_in_valid = 1'b1;
      reload = 1'b1;
      tick();
      reload = 1'b0;
      bus.data_in_valid = 1'b0;
      chk("s5_done", 32'(load_done), 0);
      chk("s5_bc", 32'(beat_count), 0);
      chk("s5_ready", 32'(bus.data_in_ready), 1);
      tick();
      chk("s5_done_later", 32'(load_done), 0);
      chk("s5_ready_later", 32'(bus.data_in_ready), 1);
      rd(31, 231);
      rd(30, 230);
      ce0 = 1'b0;
      load(0, 15);
      chk("s6_bc15", 32'(beat_count), 15);
      bus.data_in[0] = 16'd15;
      bus.data_in_valid = 1'b1;
      rst = 1'b0;
      tick();
      chk("s6_rst_ready", 32'(bus.data_in_ready), 0);
      chk("s6_rst_bc", 32'(beat_count), 0);
      chk("s6_rst_q0", 32'(q0), 0);
      chk("s6_rst_done", 32'(load_done), 0);
      rst = 1'b1;
      bus.data_in_valid = 1'b0;
      tick();
      chk("s6_ready", 32'(bus.data_in_ready), 1);
      load(0, 32);
      chk("s6_done", 32'(load_done), 1);
      chk("s6_bc", 32'(beat_count), 32);
      for (int a = 0; a < 32; a++) rd(a, a);
      rd(5, 5);
      addr0 = 6'd9;
      ce0 = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("ce0_freeze", 32'(q0), 5);
      end
      rd(9, 9);
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule
